// File: rtl/paper_ex_driver.sv
// paper_ex_driver: FIFO-buffered a/b driver with x/y/z capture; out_valid LAT+2 cycles after push, LAT+3 with dup.
// in_ready drops only when the FIFO is full; out_valid is never stalled. PAPER_EX_DRIVER_DUP_CHECK_EN adds dup-issue compare.
module paper_ex_driver #(
    parameter int DEPTH = 4,
    parameter int LAT   = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [1:0] in_ab,
    output logic       drv_a,
    output logic       drv_b,
    input  logic       rsp_x,
    input  logic       rsp_y,
    input  logic       rsp_z,
    output logic       out_valid,
    output logic [2:0] out_xyz,
    output logic       mismatch,
    output logic [7:0] err_cnt
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ORIG = 2'd1;
    localparam logic [1:0] S_DUP  = 2'd2;

    logic [1:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_cnt;
    logic [1:0]    r_state;
    logic [LAT:0]  r_live;

    logic       w_full;
    logic       w_empty;
    logic       w_push;
    logic       w_pop;
    logic       w_hold;
    logic [2:0] w_rsp;

    assign w_full   = (r_cnt == CW'(DEPTH));
    assign w_empty  = (r_cnt == '0);
    assign in_ready = !w_full;
    assign w_push   = in_valid && !w_full;
    assign w_rsp    = {rsp_x, rsp_y, rsp_z};

`ifdef PAPER_EX_DRIVER_DUP_CHECK_EN
    // The cycle after an original issue re-drives the same vector instead of popping.
    assign w_hold = (r_state == S_ORIG);
`else
    assign w_hold = 1'b0;
`endif
    assign w_pop = !w_hold && !w_empty;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= in_ab;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            drv_a   <= 1'b0;
            drv_b   <= 1'b0;
        end else if (w_pop) begin
            r_state        <= S_ORIG;
            {drv_a, drv_b} <= r_mem[r_rptr];
        end else if (w_hold) begin
            r_state <= S_DUP;
        end else begin
            r_state <= S_IDLE;
            drv_a   <= 1'b0;
            drv_b   <= 1'b0;
        end
    end

    // Stage 0 tags the vector now on drv; stage LAT tags the response now on rsp.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_live <= '0;
        end else begin
            r_live <= {r_live[LAT-1:0], w_pop | w_hold};
        end
    end

`ifdef PAPER_EX_DRIVER_DUP_CHECK_EN
    logic [LAT:0] r_dup;
    logic [2:0]   r_cmp;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_dup     <= '0;
            r_cmp     <= 3'b000;
            out_valid <= 1'b0;
            out_xyz   <= 3'b000;
            mismatch  <= 1'b0;
            err_cnt   <= 8'd0;
        end else begin
            r_dup     <= {r_dup[LAT-1:0], w_hold};
            out_valid <= r_live[LAT] && r_dup[LAT];
            if (r_live[LAT]) begin
                if (!r_dup[LAT]) begin
                    r_cmp <= w_rsp;
                end else begin
                    out_xyz <= w_rsp;
                    if (w_rsp != r_cmp) begin
                        mismatch <= 1'b1;
                        if (err_cnt != 8'hFF) begin
                            err_cnt <= err_cnt + 1'b1;
                        end
                    end
                end
            end
        end
    end
`else
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_xyz   <= 3'b000;
        end else begin
            out_valid <= r_live[LAT];
            if (r_live[LAT]) begin
                out_xyz <= w_rsp;
            end
        end
    end

    assign mismatch = 1'b0;
    assign err_cnt  = 8'd0;
`endif

endmodule

// File: tb/tb_paper_ex_driver.sv
// Bench for paper_ex_driver: models the paper-example design around the DUT and scores responses in order and in time.
module tb_paper_ex_driver;
    localparam int LAT = 3;
`ifdef PAPER_EX_DRIVER_DUP_CHECK_EN
    localparam int GAP      = 2;
    localparam int EXTRA    = 1;
    localparam bit FULL_EXP = 1'b1;
`else
    localparam int GAP      = 1;
    localparam int EXTRA    = 0;
    localparam bit FULL_EXP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [1:0] in_ab = 2'b00;
    logic       in_ready, drv_a, drv_b, out_valid, mismatch;
    logic       rsp_x, rsp_y, rsp_z;
    logic [2:0] out_xyz;
    logic [7:0] err_cnt;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    logic       flip_z = 1'b0;
    logic       saw_full = 1'b0;
    logic [2:0] got_xyz[$];
    int         got_cyc[$];
    int         push_cyc[$];

    paper_ex_driver #(.DEPTH(4), .LAT(LAT)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_ab(in_ab),
        .drv_a(drv_a), .drv_b(drv_b), .rsp_x(rsp_x), .rsp_y(rsp_y), .rsp_z(rsp_z),
        .out_valid(out_valid), .out_xyz(out_xyz), .mismatch(mismatch), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Paper-example design: x=a, y=~a, z=a^b behind three flops, sharing rst.
    logic [1:0] p1, p2;
    logic [2:0] p3;
    always @(posedge clk) begin
        if (rst) begin
            p1 <= 2'b00; p2 <= 2'b00; p3 <= 3'b000;
        end else begin
            p1 <= {drv_a, drv_b};
            p2 <= p1;
            p3 <= {p2[1], ~p2[1], p2[1] ^ p2[0]};
        end
    end
    assign rsp_x = p3[2];
    assign rsp_y = p3[1];
    assign rsp_z = p3[0] ^ flip_z;

    always @(negedge clk) begin
        if (out_valid) begin
            got_xyz.push_back(out_xyz);
            got_cyc.push_back(cyc);
        end
        if (!rst && !in_ready) saw_full = 1'b1;
    end

    function automatic logic [2:0] exp_xyz(input logic [1:0] ab);
        return {ab[1], ~ab[1], ab[1] ^ ab[0]};
    endfunction

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic push_one(input logic [1:0] ab);
        int n = 0;
        in_valid = 1'b1;
        in_ab    = ab;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            errors++;
            $display("FAIL push_timeout: in_ready=%b after %0d cycles, required 1", in_ready, n);
            in_valid = 1'b0;
        end else begin
            @(posedge clk);
            @(negedge clk);
            push_cyc.push_back(cyc);
            in_valid = 1'b0;
        end
    endtask

    task automatic clear_logs();
        got_xyz.delete();
        got_cyc.delete();
        push_cyc.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        checks++; if ({drv_a, drv_b} !== 2'b00) begin errors++; $display("FAIL reset_drv: got %b want 00", {drv_a, drv_b}); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++; if (out_xyz !== 3'b000) begin errors++; $display("FAIL reset_out_xyz: got %b want 000", out_xyz); end
        checks++; if (mismatch !== 1'b0) begin errors++; $display("FAIL reset_mismatch: got %b want 0", mismatch); end
        checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL reset_err_cnt: got %0d want 0", err_cnt); end
    endtask

    task automatic test_basic();
        logic [1:0] v;
        clear_logs();
        for (int i = 0; i < 4; i++) begin
            v = 2'(i);
            push_one(v);
        end
        repeat (20) @(negedge clk);
        checks++;
        if (got_xyz.size() != 4) begin
            errors++; $display("FAIL basic_count: got %0d responses want 4", got_xyz.size());
        end
        for (int i = 0; i < 4 && i < got_xyz.size(); i++) begin
            v = 2'(i);
            checks++;
            if (got_xyz[i] !== exp_xyz(v)) begin
                errors++; $display("FAIL basic_xyz[%0d]: got %b want %b", i, got_xyz[i], exp_xyz(v));
            end
            checks++;
            if (got_cyc[i] - push_cyc[0] != LAT + 2 + EXTRA + i * GAP) begin
                errors++; $display("FAIL basic_latency[%0d]: got %0d want %0d", i, got_cyc[i] - push_cyc[0], LAT + 2 + EXTRA + i * GAP);
            end
        end
    endtask

    task automatic test_fill();
        logic [2:0] exp_q[$];
        logic [1:0] v;
        clear_logs();
        saw_full = 1'b0;
        for (int i = 0; i < 8; i++) begin
            v = 2'($urandom_range(0, 3));
            exp_q.push_back(exp_xyz(v));
            push_one(v);
        end
        repeat (30) @(negedge clk);
        checks++;
        if (saw_full !== FULL_EXP) begin
            errors++; $display("FAIL fill_in_ready_drop: got %b want %b", saw_full, FULL_EXP);
        end
        checks++;
        if (got_xyz.size() != 8) begin
            errors++; $display("FAIL fill_count: got %0d want 8", got_xyz.size());
        end
        for (int i = 0; i < 8 && i < got_xyz.size(); i++) begin
            checks++;
            if (got_xyz[i] !== exp_q[i]) begin
                errors++; $display("FAIL fill_order[%0d]: got %b want %b", i, got_xyz[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_random();
        logic [2:0] exp_q[$];
        logic [1:0] v;
        clear_logs();
        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            v = 2'($urandom_range(0, 3));
            exp_q.push_back(exp_xyz(v));
            push_one(v);
        end
        repeat (30) @(negedge clk);
        checks++;
        if (got_xyz.size() != exp_q.size()) begin
            errors++; $display("FAIL random_count: got %0d want %0d", got_xyz.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_xyz.size(); i++) begin
            checks++;
            if (got_xyz[i] !== exp_q[i]) begin
                errors++; $display("FAIL random_xyz[%0d]: got %b want %b", i, got_xyz[i], exp_q[i]);
            end
        end
        checks++;
        if ({mismatch, err_cnt} !== 9'd0) begin
            errors++; $display("FAIL random_no_mismatch: got mismatch=%b err_cnt=%0d want 0/0", mismatch, err_cnt);
        end
    endtask

    task automatic test_idle();
        clear_logs();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checks++;
            if ({drv_a, drv_b, out_valid} !== 3'b000) begin
                errors++; $display("FAIL idle[%0d]: drv_a,drv_b,out_valid got %b want 000", i, {drv_a, drv_b, out_valid});
            end
        end
    endtask

    task automatic test_reset_midflight();
        clear_logs();
        push_one(2'b11);
        push_one(2'b10);
        push_one(2'b01);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({drv_a, drv_b, in_ready} !== 3'b001) begin
            errors++; $display("FAIL midrst_state: drv_a,drv_b,in_ready got %b want 001", {drv_a, drv_b, in_ready});
        end
        repeat (15) @(negedge clk);
        checks++;
        if (got_xyz.size() != 0) begin
            errors++; $display("FAIL midrst_no_out: got %0d pulses want 0", got_xyz.size());
        end
        test_basic();
    endtask

`ifdef PAPER_EX_DRIVER_DUP_CHECK_EN
    task automatic test_dup_single();
        clear_logs();
        push_one(2'b01);
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            checks++;
            if ({drv_a, drv_b} !== ((i < 3) ? 2'b01 : 2'b00)) begin
                errors++; $display("FAIL dup_drv[%0d]: got %b want %b", i, {drv_a, drv_b}, (i < 3) ? 2'b01 : 2'b00);
            end
        end
        repeat (10) @(negedge clk);
        checks++;
        if (got_xyz.size() != 1) begin
            errors++; $display("FAIL dup_single_count: got %0d want 1", got_xyz.size());
        end else begin
            checks++;
            if (got_xyz[0] !== 3'b011) begin errors++; $display("FAIL dup_single_xyz: got %b want 011", got_xyz[0]); end
            checks++;
            if (got_cyc[0] - push_cyc[0] != LAT + 3) begin
                errors++; $display("FAIL dup_single_latency: got %0d want %0d", got_cyc[0] - push_cyc[0], LAT + 3);
            end
        end
        checks++;
        if ({mismatch, err_cnt} !== 9'd0) begin
            errors++; $display("FAIL dup_single_flags: got mismatch=%b err_cnt=%0d want 0/0", mismatch, err_cnt);
        end
    endtask

    // The dup response of a vector pushed at edge T sits on rsp between edges T+5 and T+6.
    task automatic inject_once();
        clear_logs();
        push_one(2'b01);
        repeat (5) @(negedge clk);
        flip_z = 1'b1;
        @(negedge clk);
        flip_z = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_dup_inject();
        inject_once();
        checks++;
        if (got_xyz.size() != 1 || got_xyz[0] !== 3'b010) begin
            errors++; $display("FAIL inject_xyz: got %0d pulses first=%b want 1 pulse 010", got_xyz.size(), (got_xyz.size() > 0) ? got_xyz[0] : 3'bxxx);
        end
        checks++;
        if ({mismatch, err_cnt} !== {1'b1, 8'd1}) begin
            errors++; $display("FAIL inject_first: got mismatch=%b err_cnt=%0d want 1/1", mismatch, err_cnt);
        end
        clear_logs();
        push_one(2'b10);
        repeat (12) @(negedge clk);
        checks++;
        if ({mismatch, err_cnt} !== {1'b1, 8'd1}) begin
            errors++; $display("FAIL inject_sticky: got mismatch=%b err_cnt=%0d want 1/1", mismatch, err_cnt);
        end
        for (int i = 1; i < 300; i++) inject_once();
        checks++;
        if ({mismatch, err_cnt} !== {1'b1, 8'd255}) begin
            errors++; $display("FAIL inject_saturate: got mismatch=%b err_cnt=%0d want 1/255", mismatch, err_cnt);
        end
    endtask
`endif

    initial begin
        @(negedge clk);
        test_reset();
        test_basic();
        test_fill();
        test_random();
        test_idle();
        test_reset_midflight();
`ifdef PAPER_EX_DRIVER_DUP_CHECK_EN
        test_reset();
        test_dup_single();
        test_dup_inject();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
